// File: rtl/seq_det_ctrl.sv
// Programmable serial pattern detector: a configuration is taken over a valid/ready
// handshake, then start/stop-controlled matching runs on a gated bit stream.
module seq_det_ctrl #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic [CNT_W-1:0]   cfg_limit,
    input  logic               start,
    input  logic               stop,
    input  logic               in_valid,
    input  logic               in_bit,
    output logic               det,
    output logic [CNT_W-1:0]   match_count,
    output logic               busy,
    output logic               done,
    output logic               err_cfg
);

    typedef enum logic [1:0] {IDLE, READY, RUN, DONE} state_t;

    state_t             state;
    logic [MAX_LEN-1:0] sr, pat_q, mask, sr_nxt;
    logic [LEN_W-1:0]   len_q, fill, fill_nxt;
    logic               ovl_q;
    logic [CNT_W-1:0]   lim_q, cnt_inc;
    logic               cfg_fire, cfg_legal, hit, lim_hit;

    assign cfg_ready = (state == IDLE) || (state == READY);
    assign busy      = (state == RUN);
    assign done      = (state == DONE);
    assign cfg_fire  = cfg_valid && cfg_ready;
    assign cfg_legal = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));

    assign sr_nxt   = {sr[MAX_LEN-2:0], in_bit};
    assign fill_nxt = (fill == LEN_W'(MAX_LEN)) ? fill : fill + 1'b1;
    assign cnt_inc  = (&match_count) ? match_count : match_count + 1'b1;
    assign lim_hit  = (lim_q != '0) && (cnt_inc == lim_q);

    // Only the low len bits of the history take part in the compare.
    always_comb begin
        mask = '0;
        for (int i = 0; i < MAX_LEN; i++)
            mask[i] = (int'(len_q) > i);
    end

    assign hit = (fill_nxt >= len_q) && ((sr_nxt & mask) == (pat_q & mask));

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            sr          <= '0;
            fill        <= '0;
            det         <= 1'b0;
            match_count <= '0;
            err_cfg     <= 1'b0;
            pat_q       <= '0;
            len_q       <= '0;
            ovl_q       <= 1'b0;
            lim_q       <= '0;
        end else begin
            det <= 1'b0;
            case (state)
                IDLE: begin
                    if (cfg_fire) begin
                        if (cfg_legal) begin
                            pat_q   <= cfg_pattern;
                            len_q   <= cfg_len;
                            ovl_q   <= cfg_overlap;
                            lim_q   <= cfg_limit;
                            err_cfg <= 1'b0;
                            state   <= READY;
                        end else begin
                            err_cfg <= 1'b1;
                        end
                    end
                end
                READY: begin
                    // A configuration offered with start takes priority.
                    if (cfg_fire) begin
                        if (cfg_legal) begin
                            pat_q <= cfg_pattern;
                            len_q <= cfg_len;
                            ovl_q <= cfg_overlap;
                            lim_q <= cfg_limit;
                        end else begin
                            err_cfg <= 1'b1;
                        end
                    end else if (start) begin
                        sr          <= '0;
                        fill        <= '0;
                        match_count <= '0;
                        state       <= RUN;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state <= READY;
                    end else if (in_valid) begin
                        sr   <= sr_nxt;
                        fill <= (hit && !ovl_q) ? '0 : fill_nxt;
                        if (hit) begin
                            det         <= 1'b1;
                            match_count <= cnt_inc;
                            if (lim_hit)
                                state <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (stop) begin
                        state <= READY;
                    end else if (start) begin
                        sr          <= '0;
                        fill        <= '0;
                        match_count <= '0;
                        state       <= RUN;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Scoreboard bench for seq_det_ctrl: expected match counts are queued per expected
// det pulse and a monitor pops them whenever det is seen.
module tb_seq_det_ctrl;

    localparam int MAX_LEN = 8;
    localparam int LEN_W   = 4;
    localparam int CNT_W   = 8;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               cfg_valid = 1'b0;
    logic               cfg_ready;
    logic [MAX_LEN-1:0] cfg_pattern = '0;
    logic [LEN_W-1:0]   cfg_len = '0;
    logic               cfg_overlap = 1'b0;
    logic [CNT_W-1:0]   cfg_limit = '0;
    logic               start = 1'b0;
    logic               stop = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_bit = 1'b0;
    logic               det;
    logic [CNT_W-1:0]   match_count;
    logic               busy;
    logic               done;
    logic               err_cfg;

    int total = 0;
    int bad   = 0;
    int exp_q[$];

    seq_det_ctrl #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .cfg_limit(cfg_limit),
        .start(start), .stop(stop),
        .in_valid(in_valid), .in_bit(in_bit),
        .det(det), .match_count(match_count),
        .busy(busy), .done(done), .err_cfg(err_cfg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every det pulse must match a queued expectation.
    always @(negedge clk) begin
        if (!reset && det) begin
            if (exp_q.size() == 0) begin
                chk("det_unexpected", 1, 0);
            end else begin
                chk("det_cnt", int'(match_count), exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic cfg(input logic [MAX_LEN-1:0] p, input int len, input bit ovl, input int lim);
        cfg_valid   = 1'b1;
        cfg_pattern = p;
        cfg_len     = LEN_W'(len);
        cfg_overlap = ovl;
        cfg_limit   = CNT_W'(lim);
        tick();
        cfg_valid   = 1'b0;
    endtask

    task automatic go();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic halt();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    // exp_cnt < 0 means no det expected for this sample.
    task automatic sample(input bit b, input int exp_cnt);
        if (exp_cnt >= 0) exp_q.push_back(exp_cnt);
        in_valid = 1'b1;
        in_bit   = b;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        tick();
        tick();
        chk(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int s1[7]  = '{1, 0, 0, 1, 0, 0, 1};
        int e1[7]  = '{-1, -1, -1, 1, -1, -1, 2};

        // Reset state
        do_reset();
        chk("rst_cfg_ready", cfg_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_det", det, 0);
        chk("rst_err", err_cfg, 0);
        chk("rst_cnt", match_count, 0);

        // 001 non-overlap, unlimited
        cfg(8'b001, 3, 0, 0);
        chk("t1_ready", cfg_ready, 1);
        go();
        chk("t1_busy", busy, 1);
        chk("t1_cfg_ready", cfg_ready, 0);
        for (int i = 0; i < 7; i++) sample(s1[i][0], e1[i]);
        drain("t1_q_empty");
        chk("t1_cnt", match_count, 2);
        halt();

        // 11 overlap then non-overlap
        cfg(8'b11, 2, 1, 0);
        go();
        sample(1, -1); sample(1, 1); sample(1, 2); sample(1, 3);
        drain("t2o_q_empty");
        chk("t2o_cnt", match_count, 3);
        halt();
        cfg(8'b11, 2, 0, 0);
        go();
        sample(1, -1); sample(1, 1); sample(1, -1); sample(1, 2);
        drain("t2n_q_empty");
        chk("t2n_cnt", match_count, 2);
        halt();

        // limit 2 -> DONE, later samples ignored, restart
        cfg(8'b001, 3, 0, 2);
        go();
        sample(0, -1); sample(0, -1); sample(1, 1);
        sample(0, -1); sample(0, -1); sample(1, 2);
        chk("t3_done", done, 1);
        chk("t3_busy", busy, 0);
        chk("t3_cfg_ready", cfg_ready, 0);
        sample(0, -1); sample(0, -1); sample(1, -1);
        drain("t3_q_empty");
        chk("t3_cnt_held", match_count, 2);
        chk("t3_still_done", done, 1);
        go();
        chk("t3_restart_busy", busy, 1);
        chk("t3_restart_cnt", match_count, 0);
        halt();

        // Illegal lengths
        do_reset();
        cfg(8'b001, 0, 0, 0);
        chk("t4_err", err_cfg, 1);
        chk("t4_idle_cfg_ready", cfg_ready, 1);
        go();
        chk("t4_start_ignored", busy, 0);
        cfg(8'b001, 3, 0, 0);
        chk("t4_err_clr", err_cfg, 0);
        cfg(8'b101, 9, 1, 0);
        chk("t4_err_len9", err_cfg, 1);
        go();
        chk("t4_busy", busy, 1);
        sample(0, -1); sample(0, -1); sample(1, 1);
        drain("t4_q_empty");
        chk("t4_cnt_old_cfg", match_count, 1);
        halt();

        // stop beats in_valid
        cfg(8'b001, 3, 0, 0);
        go();
        sample(0, -1); sample(0, -1);
        stop = 1'b1; in_valid = 1'b1; in_bit = 1'b1;
        tick();
        stop = 1'b0; in_valid = 1'b0;
        chk("t5_det", det, 0);
        chk("t5_busy", busy, 0);
        chk("t5_cfg_ready", cfg_ready, 1);
        chk("t5_cnt", match_count, 0);
        drain("t5_q_empty");

        // gapped stream, then reset mid-RUN
        go();
        for (int i = 0; i < 7; i++) begin
            sample(s1[i][0], e1[i]);
            repeat (i % 4) tick();
        end
        drain("t6_q_empty");
        chk("t6_cnt", match_count, 2);
        sample(0, -1);
        do_reset();
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_done", done, 0);
        chk("t6_rst_det", det, 0);
        chk("t6_rst_cnt", match_count, 0);
        chk("t6_rst_err", err_cfg, 0);
        chk("t6_rst_cfg_ready", cfg_ready, 1);
        go();
        chk("t6_cfg_discarded", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
